// File: rtl/rom_load_sequencer.sv
// ROM download sequencer: turns the HPS ioctl byte stream into per-region ROM writes
// and holds the core in reset until a complete image has been loaded.
module rom_load_sequencer #(
  parameter int ADDR_W      = 17,
  parameter int R0_SIZE     = 2048,
  parameter int R1_SIZE     = 2048,
  parameter int R2_SIZE     = 512,
  parameter int R3_SIZE     = 256,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dn_download,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  input  logic              user_reset,
  output logic [3:0]        rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   byte_count
);

  localparam int CW = ADDR_W + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  // Cumulative region end addresses; END3 is also the expected image size.
  localparam logic [ADDR_W:0] END0 = CW'(R0_SIZE);
  localparam logic [ADDR_W:0] END1 = CW'(R0_SIZE + R1_SIZE);
  localparam logic [ADDR_W:0] END2 = CW'(R0_SIZE + R1_SIZE + R2_SIZE);
  localparam logic [ADDR_W:0] END3 = CW'(R0_SIZE + R1_SIZE + R2_SIZE + R3_SIZE);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_t;

  state_t            state, state_n;
  logic [3:0]        rom_we_n;
  logic [ADDR_W-1:0] rom_addr_n;
  logic [7:0]        rom_data_n;
  logic              core_reset_n, load_done_n, load_err_n;
  logic [ADDR_W:0]   byte_count_n, count_after_wr;
  logic [HW-1:0]     hold_cnt, hold_cnt_n;

  logic [ADDR_W:0]   addr_ext;
  logic [3:0]        dec_we;
  logic [ADDR_W-1:0] dec_base;
  logic              in_range;

  assign addr_ext = {1'b0, dn_addr};

  always_comb begin
    dec_we   = 4'b0000;
    dec_base = '0;
    in_range = 1'b1;
    if (addr_ext < END0) begin
      dec_we = 4'b0001;
    end else if (addr_ext < END1) begin
      dec_we   = 4'b0010;
      dec_base = END0[ADDR_W-1:0];
    end else if (addr_ext < END2) begin
      dec_we   = 4'b0100;
      dec_base = END1[ADDR_W-1:0];
    end else if (addr_ext < END3) begin
      dec_we   = 4'b1000;
      dec_base = END2[ADDR_W-1:0];
    end else begin
      in_range = 1'b0;
    end
  end

  always_comb begin
    state_n        = state;
    rom_we_n       = 4'b0000;
    rom_addr_n     = rom_addr;
    rom_data_n     = rom_data;
    core_reset_n   = 1'b1;
    load_done_n    = 1'b0;
    load_err_n     = load_err;
    byte_count_n   = byte_count;
    hold_cnt_n     = hold_cnt;
    count_after_wr = byte_count;

    case (state)
      S_IDLE: begin
        if (dn_download) begin
          state_n      = S_LOAD;
          byte_count_n = '0;
          load_err_n   = 1'b0;
        end
      end

      // A write coinciding with the download falling edge still lands and counts.
      S_LOAD: begin
        if (dn_wr) begin
          if (in_range) begin
            rom_we_n   = dec_we;
            rom_addr_n = dn_addr - dec_base;
            rom_data_n = dn_data;
            if (byte_count != '1)
              count_after_wr = byte_count + CW'(1);
          end else begin
            load_err_n = 1'b1;
          end
        end
        byte_count_n = count_after_wr;
        if (!dn_download) begin
          state_n    = S_HOLD;
          hold_cnt_n = '0;
          if (count_after_wr != END3)
            load_err_n = 1'b1;
        end
      end

      S_HOLD: begin
        if (dn_download) begin
          state_n      = S_LOAD;
          hold_cnt_n   = '0;
          byte_count_n = '0;
          load_err_n   = 1'b0;
        end else if (hold_cnt == HOLD_LAST) begin
          hold_cnt_n = '0;
          if (load_err) begin
            state_n = S_IDLE;
          end else begin
            state_n      = S_RUN;
            core_reset_n = user_reset;
            load_done_n  = 1'b1;
          end
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end

      S_RUN: begin
        if (dn_download) begin
          state_n      = S_LOAD;
          byte_count_n = '0;
          load_err_n   = 1'b0;
        end else begin
          core_reset_n = user_reset;
          load_done_n  = 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      rom_we     <= 4'b0000;
      rom_addr   <= '0;
      rom_data   <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      byte_count <= '0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      rom_we     <= rom_we_n;
      rom_addr   <= rom_addr_n;
      rom_data   <= rom_data_n;
      core_reset <= core_reset_n;
      load_done  <= load_done_n;
      load_err   <= load_err_n;
      byte_count <= byte_count_n;
      hold_cnt   <= hold_cnt_n;
    end
  end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed bench for rom_load_sequencer: full/short/oversize loads, hold timing,
// user reset in RUN, restart during HOLD and reset mid-load.
module tb_rom_load_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset, dn_download, dn_wr, user_reset;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic [3:0]  rom_we;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        core_reset, load_done, load_err;
  logic [17:0] byte_count;

  int chk_cnt = 0;
  int pass_cnt = 0;

  int hits [4];
  int odd_we, bad_data, nz_after;
  logic [3:0]  cap_we   [0:5119];
  logic [16:0] cap_addr [0:5119];

  rom_load_sequencer dut (
    .clk_sys(clk_sys), .reset(reset), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .user_reset(user_reset),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
    .core_reset(core_reset), .load_done(load_done), .load_err(load_err),
    .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) hits[i] = 0;
    odd_we = 0; bad_data = 0; nz_after = 0;
  endtask

  // One byte per address, gap cycles apart; optionally drop dn_download with the last byte.
  task automatic stream(input int first, input int last, input int gap, input bit drop_last);
    logic [7:0] exp_d;
    for (int a = first; a <= last; a++) begin
      dn_wr   = 1'b1;
      dn_addr = 17'(a);
      exp_d   = 8'(a);
      dn_data = exp_d ^ 8'h5A;
      if (drop_last && a == last) dn_download = 1'b0;
      tick();
      dn_wr = 1'b0;
      if (a < 5120) begin
        cap_we[a]   = rom_we;
        cap_addr[a] = rom_addr;
      end
      case (rom_we)
        4'b0000: ;
        4'b0001: hits[0]++;
        4'b0010: hits[1]++;
        4'b0100: hits[2]++;
        4'b1000: hits[3]++;
        default: odd_we++;
      endcase
      if (rom_we != 4'b0000 && rom_data !== (exp_d ^ 8'h5A)) bad_data++;
      for (int g = 1; g < gap; g++) begin
        tick();
        if (rom_we !== 4'b0000) nz_after++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; dn_download = 1'b0; dn_wr = 1'b0; user_reset = 1'b0;
    dn_addr = '0; dn_data = '0;
    tick(); tick();
    chk_cnt++; if (core_reset !== 1'b1) $display("[TB] FAIL rst_core_reset got %0b want 1", core_reset); else pass_cnt++;
    chk_cnt++; if (rom_we !== 4'b0000) $display("[TB] FAIL rst_rom_we got %b want 0000", rom_we); else pass_cnt++;
    chk_cnt++; if (load_done !== 1'b0 || load_err !== 1'b0) $display("[TB] FAIL rst_flags got done=%0b err=%0b want 0 0", load_done, load_err); else pass_cnt++;
    chk_cnt++; if (byte_count !== 18'd0 || rom_addr !== 17'd0 || rom_data !== 8'd0) $display("[TB] FAIL rst_regs got cnt=%0d addr=%0d data=%0h want 0", byte_count, rom_addr, rom_data); else pass_cnt++;
    reset = 1'b0;
    tick();
    chk_cnt++; if (core_reset !== 1'b1) $display("[TB] FAIL idle_core_reset got %0b want 1", core_reset); else pass_cnt++;
  endtask

  task automatic test_full_load();
    int early_drop;
    dn_download = 1'b1;
    tick();
    clear_stats();
    stream(0, 4863, 3, 1'b0);
    chk_cnt++; if (cap_we[0] !== 4'b0001 || cap_addr[0] !== 17'd0) $display("[TB] FAIL full_a0 got we=%b addr=%0d want 0001 0", cap_we[0], cap_addr[0]); else pass_cnt++;
    chk_cnt++; if (cap_we[2047] !== 4'b0001 || cap_addr[2047] !== 17'd2047) $display("[TB] FAIL full_a2047 got we=%b addr=%0d want 0001 2047", cap_we[2047], cap_addr[2047]); else pass_cnt++;
    chk_cnt++; if (cap_we[2048] !== 4'b0010 || cap_addr[2048] !== 17'd0) $display("[TB] FAIL full_a2048 got we=%b addr=%0d want 0010 0", cap_we[2048], cap_addr[2048]); else pass_cnt++;
    chk_cnt++; if (cap_we[4095] !== 4'b0010 || cap_addr[4095] !== 17'd2047) $display("[TB] FAIL full_a4095 got we=%b addr=%0d want 0010 2047", cap_we[4095], cap_addr[4095]); else pass_cnt++;
    chk_cnt++; if (cap_we[4096] !== 4'b0100 || cap_addr[4096] !== 17'd0) $display("[TB] FAIL full_a4096 got we=%b addr=%0d want 0100 0", cap_we[4096], cap_addr[4096]); else pass_cnt++;
    chk_cnt++; if (cap_we[4607] !== 4'b0100 || cap_addr[4607] !== 17'd511) $display("[TB] FAIL full_a4607 got we=%b addr=%0d want 0100 511", cap_we[4607], cap_addr[4607]); else pass_cnt++;
    chk_cnt++; if (cap_we[4608] !== 4'b1000 || cap_addr[4608] !== 17'd0) $display("[TB] FAIL full_a4608 got we=%b addr=%0d want 1000 0", cap_we[4608], cap_addr[4608]); else pass_cnt++;
    chk_cnt++; if (cap_we[4863] !== 4'b1000 || cap_addr[4863] !== 17'd255) $display("[TB] FAIL full_a4863 got we=%b addr=%0d want 1000 255", cap_we[4863], cap_addr[4863]); else pass_cnt++;
    chk_cnt++; if (hits[0] != 2048 || hits[1] != 2048 || hits[2] != 512 || hits[3] != 256 || odd_we != 0)
      $display("[TB] FAIL full_hits got %0d %0d %0d %0d odd=%0d want 2048 2048 512 256 0", hits[0], hits[1], hits[2], hits[3], odd_we); else pass_cnt++;
    chk_cnt++; if (bad_data != 0) $display("[TB] FAIL full_data got %0d bad bytes want 0", bad_data); else pass_cnt++;
    chk_cnt++; if (nz_after != 0) $display("[TB] FAIL full_we_deassert got %0d stuck strobes want 0", nz_after); else pass_cnt++;
    chk_cnt++; if (core_reset !== 1'b1 || load_done !== 1'b0) $display("[TB] FAIL full_in_load got rst=%0b done=%0b want 1 0", core_reset, load_done); else pass_cnt++;
    dn_download = 1'b0;
    early_drop = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (core_reset !== 1'b1 || load_done !== 1'b0) early_drop++;
    end
    chk_cnt++; if (early_drop != 0) $display("[TB] FAIL full_hold got %0d early release cycles want 0", early_drop); else pass_cnt++;
    tick();
    chk_cnt++; if (core_reset !== 1'b0 || load_done !== 1'b1 || load_err !== 1'b0)
      $display("[TB] FAIL full_run got rst=%0b done=%0b err=%0b want 0 1 0", core_reset, load_done, load_err); else pass_cnt++;
    chk_cnt++; if (byte_count !== 18'd4864) $display("[TB] FAIL full_count got %0d want 4864", byte_count); else pass_cnt++;
  endtask

  task automatic test_short_image();
    dn_download = 1'b1;
    tick();
    chk_cnt++; if (core_reset !== 1'b1 || load_done !== 1'b0 || byte_count !== 18'd0)
      $display("[TB] FAIL short_enter got rst=%0b done=%0b cnt=%0d want 1 0 0", core_reset, load_done, byte_count); else pass_cnt++;
    clear_stats();
    stream(0, 4000, 1, 1'b0);
    dn_download = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    chk_cnt++; if (load_err !== 1'b1 || load_done !== 1'b0 || core_reset !== 1'b1)
      $display("[TB] FAIL short_end got err=%0b done=%0b rst=%0b want 1 0 1", load_err, load_done, core_reset); else pass_cnt++;
    chk_cnt++; if (byte_count !== 18'd4001) $display("[TB] FAIL short_count got %0d want 4001", byte_count); else pass_cnt++;
    for (int i = 0; i < 20; i++) tick();
    chk_cnt++; if (core_reset !== 1'b1 || load_done !== 1'b0) $display("[TB] FAIL short_idle got rst=%0b done=%0b want 1 0", core_reset, load_done); else pass_cnt++;
  endtask

  task automatic test_oversize();
    dn_download = 1'b1;
    tick();
    chk_cnt++; if (load_err !== 1'b0 || byte_count !== 18'd0) $display("[TB] FAIL over_enter got err=%0b cnt=%0d want 0 0", load_err, byte_count); else pass_cnt++;
    clear_stats();
    stream(0, 4863, 1, 1'b0);
    chk_cnt++; if (load_err !== 1'b0) $display("[TB] FAIL over_before got err=%0b want 0", load_err); else pass_cnt++;
    stream(4864, 4864, 1, 1'b0);
    chk_cnt++; if (rom_we !== 4'b0000 || load_err !== 1'b1) $display("[TB] FAIL over_4864 got we=%b err=%0b want 0000 1", rom_we, load_err); else pass_cnt++;
    stream(5000, 5000, 1, 1'b0);
    chk_cnt++; if (rom_we !== 4'b0000) $display("[TB] FAIL over_5000 got we=%b want 0000", rom_we); else pass_cnt++;
    chk_cnt++; if (byte_count !== 18'd4864) $display("[TB] FAIL over_count got %0d want 4864", byte_count); else pass_cnt++;
    dn_download = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    chk_cnt++; if (load_err !== 1'b1 || load_done !== 1'b0 || core_reset !== 1'b1 || byte_count !== 18'd4864)
      $display("[TB] FAIL over_end got err=%0b done=%0b rst=%0b cnt=%0d want 1 0 1 4864", load_err, load_done, core_reset, byte_count); else pass_cnt++;
  endtask

  task automatic test_user_reset();
    int highs, done_low;
    dn_download = 1'b1;
    tick();
    clear_stats();
    stream(0, 4863, 1, 1'b1);
    chk_cnt++; if (cap_we[4863] !== 4'b1000 || byte_count !== 18'd4864)
      $display("[TB] FAIL ur_last_byte got we=%b cnt=%0d want 1000 4864", cap_we[4863], byte_count); else pass_cnt++;
    for (int i = 0; i < 15; i++) tick();
    chk_cnt++; if (core_reset !== 1'b1) $display("[TB] FAIL ur_hold got rst=%0b want 1", core_reset); else pass_cnt++;
    tick();
    chk_cnt++; if (core_reset !== 1'b0 || load_done !== 1'b1 || load_err !== 1'b0)
      $display("[TB] FAIL ur_run got rst=%0b done=%0b err=%0b want 0 1 0", core_reset, load_done, load_err); else pass_cnt++;
    user_reset = 1'b1;
    chk_cnt++; if (core_reset !== 1'b0) $display("[TB] FAIL ur_latency got rst=%0b want 0", core_reset); else pass_cnt++;
    highs = 0; done_low = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (core_reset === 1'b1) highs++;
      if (load_done !== 1'b1) done_low++;
    end
    user_reset = 1'b0;
    tick();
    chk_cnt++; if (highs != 5 || core_reset !== 1'b0) $display("[TB] FAIL ur_pulse got highs=%0d rst=%0b want 5 0", highs, core_reset); else pass_cnt++;
    chk_cnt++; if (done_low != 0 || load_done !== 1'b1) $display("[TB] FAIL ur_done got drops=%0d done=%0b want 0 1", done_low, load_done); else pass_cnt++;
    dn_wr = 1'b1; dn_addr = 17'd10; dn_data = 8'hEE;
    tick();
    dn_wr = 1'b0;
    chk_cnt++; if (rom_we !== 4'b0000 || byte_count !== 18'd4864)
      $display("[TB] FAIL run_wr_ignored got we=%b cnt=%0d want 0000 4864", rom_we, byte_count); else pass_cnt++;
  endtask

  task automatic test_hold_restart();
    int drops;
    dn_download = 1'b1;
    tick();
    chk_cnt++; if (core_reset !== 1'b1 || load_done !== 1'b0 || byte_count !== 18'd0)
      $display("[TB] FAIL rs_enter got rst=%0b done=%0b cnt=%0d want 1 0 0", core_reset, load_done, byte_count); else pass_cnt++;
    clear_stats();
    stream(0, 4863, 1, 1'b0);
    dn_download = 1'b0;
    drops = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (core_reset !== 1'b1) drops++;
    end
    dn_download = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (core_reset !== 1'b1) drops++;
    end
    chk_cnt++; if (drops != 0) $display("[TB] FAIL rs_core_reset got %0d low cycles want 0", drops); else pass_cnt++;
    chk_cnt++; if (byte_count !== 18'd0 || load_err !== 1'b0 || load_done !== 1'b0)
      $display("[TB] FAIL rs_reload got cnt=%0d err=%0b done=%0b want 0 0 0", byte_count, load_err, load_done); else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    clear_stats();
    stream(0, 99, 1, 1'b0);
    chk_cnt++; if (byte_count !== 18'd100) $display("[TB] FAIL mid_count got %0d want 100", byte_count); else pass_cnt++;
    reset = 1'b1; dn_wr = 1'b1; dn_addr = 17'd100; dn_data = 8'h77;
    tick();
    dn_wr = 1'b0;
    chk_cnt++; if (rom_we !== 4'b0000 || rom_addr !== 17'd0 || rom_data !== 8'd0)
      $display("[TB] FAIL mid_rst_bus got we=%b addr=%0d data=%0h want 0000 0 0", rom_we, rom_addr, rom_data); else pass_cnt++;
    chk_cnt++; if (core_reset !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 || byte_count !== 18'd0)
      $display("[TB] FAIL mid_rst_flags got rst=%0b done=%0b err=%0b cnt=%0d want 1 0 0 0", core_reset, load_done, load_err, byte_count); else pass_cnt++;
    reset = 1'b0;
    tick();
    clear_stats();
    stream(0, 4863, 1, 1'b0);
    dn_download = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    chk_cnt++; if (load_done !== 1'b1 || load_err !== 1'b0 || core_reset !== 1'b0 || byte_count !== 18'd4864)
      $display("[TB] FAIL mid_reload got done=%0b err=%0b rst=%0b cnt=%0d want 1 0 0 4864", load_done, load_err, core_reset, byte_count); else pass_cnt++;
    chk_cnt++; if (hits[0] != 2048 || hits[3] != 256 || bad_data != 0)
      $display("[TB] FAIL mid_reload_hits got r0=%0d r3=%0d bad=%0d want 2048 256 0", hits[0], hits[3], bad_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_short_image();
    test_oversize();
    test_user_reset();
    test_hold_restart();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
